eth_sb_req_arbiter: RTL and testbench

ETH_SB_REQ_ARBITER -- requirements
Module: eth_sb_req_arbiter

---
 rtl/eth_sb_req_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_eth_sb_req_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_sb_req_arbiter.sv
// eth_sb_req_arbiter
// Round-robin arbiter that funnels NUM_REQ sideband requesters into a single
// downstream core port. One transaction is in flight at a time: IDLE picks a
// winner and latches its payload, BUSY presents it downstream until ready or
// timeout, RELEASE drops valid for a cycle while the completion pulse is out.
// Every output is a flop; the comb processes compute next-cycle values.

module eth_sb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    // Derived; not meant to be overridden.
    parameter int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
    input  logic [NUM_REQ*4-1:0]             i_req_wstrb,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic [DATA_WIDTH-1:0]            o_req_rdata,
    output logic                             o_req_slverr,
    output logic                             o_req_timeout,
    output logic [GW-1:0]                    o_grant_id,
    output logic                             o_busy,
    output logic                             o_m_core_valid,
    output logic [ADDR_WIDTH-1:0]            o_m_core_addr,
    output logic [DATA_WIDTH-1:0]            o_m_core_wdata,
    output logic [3:0]                       o_m_core_wstrb,
    input  logic                             i_m_core_ready,
    input  logic [DATA_WIDTH-1:0]            i_m_core_rdata,
    input  logic                             i_m_axi_slverr
);

    // Timeout fires on the edge that closes the TIMEOUT_CYCLES-th BUSY cycle;
    // the counter reads 0 in the first BUSY cycle, so compare against N-1.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [GW:0] NREQ_W  = (GW+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [3:0]            wstrb;
    } req_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [GW-1:0]          last_winner;
    logic [15:0]            tmo_cnt;
    req_t [NUM_REQ-1:0]     reqs;

    logic [GW-1:0]          rr_pick;
    logic [GW:0]            rr_idx;
    logic                   any_req;
    logic                   grant_now;
    logic                   done_ok;
    logic                   tmo_hit;

    logic [NUM_REQ-1:0]     ready_d;
    logic [DATA_WIDTH-1:0]  rdata_d;
    logic                   slverr_d;
    logic                   timeout_d;
    logic                   valid_d;
    logic                   busy_d;

    // Unpack the flat requester buses into one struct per requester.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        assign reqs[k] = {i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH],
                          i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH],
                          i_req_wstrb[k*4 +: 4]};
    end

    assign any_req   = |i_req_valid;
    assign grant_now = (state == ST_IDLE) && any_req;
    // Ready beats timeout when both land on the same edge.
    assign done_ok   = (state == ST_BUSY) && i_m_core_ready;
    assign tmo_hit   = (state == ST_BUSY) && !i_m_core_ready && (tmo_cnt == TO_LAST);

    // Round-robin search: scan from the farthest candidate back to
    // last_winner+1 so the nearest valid index overwrites the pick last.
    always_comb begin
        rr_pick = last_winner;
        rr_idx  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            rr_idx = {1'b0, last_winner} + (GW+1)'(i);
            if (rr_idx >= NREQ_W) rr_idx = rr_idx - NREQ_W;
            if (i_req_valid[rr_idx[GW-1:0]]) rr_pick = rr_idx[GW-1:0];
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (any_req)            state_nxt = ST_BUSY;
            ST_BUSY:    if (done_ok || tmo_hit) state_nxt = ST_RELEASE;
            ST_RELEASE:                         state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next-cycle values for the registered outputs.
    always_comb begin
        ready_d   = '0;
        rdata_d   = '0;
        slverr_d  = 1'b0;
        timeout_d = 1'b0;
        valid_d   = (state_nxt == ST_BUSY);
        busy_d    = (state_nxt != ST_IDLE);
        if (done_ok) begin
            ready_d[o_grant_id] = 1'b1;
            rdata_d             = i_m_core_rdata;
            slverr_d            = i_m_axi_slverr;
        end else if (tmo_hit) begin
            ready_d[o_grant_id] = 1'b1;
            timeout_d           = 1'b1;
        end
    end

    // Output registers for handshake and status.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_req_ready    <= '0;
            o_req_rdata    <= '0;
            o_req_slverr   <= 1'b0;
            o_req_timeout  <= 1'b0;
            o_m_core_valid <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            o_req_ready    <= ready_d;
            o_req_rdata    <= rdata_d;
            o_req_slverr   <= slverr_d;
            o_req_timeout  <= timeout_d;
            o_m_core_valid <= valid_d;
            o_busy         <= busy_d;
        end
    end

    // Grant index and payload latch; captured only on the grant edge so
    // requester-side changes during BUSY never reach the core port.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_grant_id     <= '0;
            o_m_core_addr  <= '0;
            o_m_core_wdata <= '0;
            o_m_core_wstrb <= '0;
        end else if (grant_now) begin
            o_grant_id     <= rr_pick;
            o_m_core_addr  <= reqs[rr_pick].addr;
            o_m_core_wdata <= reqs[rr_pick].wdata;
            o_m_core_wstrb <= reqs[rr_pick].wstrb;
        end
    end

    // BUSY cycle counter: cleared on the grant edge, counts while BUSY holds.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                                   tmo_cnt <= '0;
        else if (grant_now)                               tmo_cnt <= '0;
        else if (state == ST_BUSY && state_nxt == ST_BUSY) tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Round-robin pointer advances once the transaction has fully released;
    // reset value makes requester 0 first in line.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                last_winner <= GW'(NUM_REQ - 1);
        else if (state == ST_RELEASE)  last_winner <= o_grant_id;
    end

    // Structural invariants of the handshake.
    a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_req_ready));
    a_valid_busy: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_m_core_valid |-> o_busy);
    a_ready_no_valid: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (o_req_ready != '0) |-> !o_m_core_valid);

endmodule

// File: tb/tb_eth_sb_req_arbiter.sv
// Scoreboard bench for eth_sb_req_arbiter: tests push expected grants and
// completions, a negedge monitor pops and compares them as the DUT acts.

module tb_eth_sb_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        int            id;
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          tmo;
        int            blen;
    } done_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NR-1:0]       tv;
    logic [NR*AW-1:0]    req_addr;
    logic [NR*DW-1:0]    req_wdata;
    logic [NR*4-1:0]     req_wstrb;
    logic [NR-1:0]       req_ready;
    logic [DW-1:0]       req_rdata;
    logic                req_slverr, req_timeout, busy, m_valid;
    logic [1:0]          grant_id;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_wdata;
    logic [3:0]          m_wstrb;
    logic                m_ready;
    logic [DW-1:0]       m_rdata;
    logic                m_slverr;

    logic [AW-1:0]       t_addr [NR];
    logic [DW-1:0]       t_wdata[NR];
    logic [3:0]          t_wstrb[NR];

    int    exp_grant[$];
    done_t exp_done[$];
    int    n_chk = 0;
    int    n_pass = 0;

    bit            resp_en, resp_force, resp_use_addr, resp_slverr;
    int            resp_delay;
    logic [DW-1:0] resp_rdata;

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        for (int k = 0; k < NR; k++) begin
            req_addr[k*AW +: AW]  = t_addr[k];
            req_wdata[k*DW +: DW] = t_wdata[k];
            req_wstrb[k*4 +: 4]   = t_wstrb[k];
        end
    end

    eth_sb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(tv), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_wstrb(req_wstrb),
        .o_req_ready(req_ready), .o_req_rdata(req_rdata),
        .o_req_slverr(req_slverr), .o_req_timeout(req_timeout),
        .o_grant_id(grant_id), .o_busy(busy),
        .o_m_core_valid(m_valid), .o_m_core_addr(m_addr),
        .o_m_core_wdata(m_wdata), .o_m_core_wstrb(m_wstrb),
        .i_m_core_ready(m_ready), .i_m_core_rdata(m_rdata),
        .i_m_axi_slverr(m_slverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic done_t mk_done(int id, logic [DW-1:0] rd, logic se, logic tm, int bl);
        done_t d;
        d.id = id; d.rdata = rd; d.slverr = se; d.tmo = tm; d.blen = bl;
        return d;
    endfunction

    // Downstream model: answers resp_delay cycles into BUSY; drives junk
    // data and a set error flag whenever it is not answering.
    int rv_cnt = 0;
    initial begin
        m_ready = 1'b0; m_rdata = '0; m_slverr = 1'b0;
        forever begin
            @(negedge clk);
            if (m_valid) rv_cnt++; else rv_cnt = 0;
            if (resp_force || (resp_en && m_valid && rv_cnt == resp_delay)) begin
                m_ready  = 1'b1;
                m_rdata  = resp_use_addr ? {8'h5A, m_addr} : resp_rdata;
                m_slverr = resp_slverr;
            end else begin
                m_ready  = 1'b0;
                m_rdata  = 32'hBAD0_BAD0;
                m_slverr = 1'b1;
            end
        end
    end

    // Monitor: grants, payload stability, completions.
    int              cyc = 0, last_cyc = 0, vlen = 0, g;
    bit              prev_v = 0, have_last = 0;
    logic [59:0]     snap = '0;
    done_t           d;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            vlen = 0; prev_v = 0; have_last = 0;
        end else begin
            if (m_valid && !prev_v) begin
                chk("grant_expected", 64'(exp_grant.size() != 0), 64'd1);
                snap = {m_addr, m_wdata, m_wstrb};
                if (exp_grant.size() != 0) begin
                    g = exp_grant.pop_front();
                    chk("grant_id", 64'(grant_id), 64'(g));
                    chk("grant_payload", 64'({m_addr, m_wdata, m_wstrb}),
                        64'({t_addr[g], t_wdata[g], t_wstrb[g]}));
                    snap = {t_addr[g], t_wdata[g], t_wstrb[g]};
                end
                if (have_last) chk("grant_gap", 64'((cyc - last_cyc) >= 3), 64'd1);
                have_last = 1; last_cyc = cyc;
            end
            if (m_valid) begin
                vlen++;
                chk("busy_hold", 64'({m_addr, m_wdata, m_wstrb}), 64'(snap));
                chk("busy_flag", 64'(busy), 64'd1);
            end
            if (req_ready != '0) begin
                chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
                if (exp_done.size() != 0) begin
                    d = exp_done.pop_front();
                    chk("done_vec", 64'(req_ready), 64'(4'b0001 << d.id));
                    chk("done_rdata", 64'(req_rdata), 64'(d.rdata));
                    chk("done_slverr", 64'(req_slverr), 64'(d.slverr));
                    chk("done_timeout", 64'(req_timeout), 64'(d.tmo));
                    chk("busy_len", 64'(vlen), 64'(d.blen));
                end
                chk("release_valid", 64'(m_valid), 64'd0);
                chk("release_busy", 64'(busy), 64'd1);
                vlen = 0;
            end else begin
                chk("quiet_flags", 64'({req_slverr, req_timeout}), 64'd0);
            end
            prev_v = m_valid;
        end
    end

    // Wait for the next grant (a fresh rise of m_valid), bounded.
    task automatic wait_grant(input int budget);
        int n = 0;
        while (m_valid && n < budget) begin @(negedge clk); n++; end
        do begin @(negedge clk); n++; end while (!m_valid && n < budget);
        chk("grant_wait", 64'(m_valid), 64'd1);
    endtask

    task automatic issue(input int k);
        tv[k] = 1'b1;
        wait_grant(40);
        tv[k] = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while ((exp_grant.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(negedge clk); n++;
        end
        chk("drain", 64'(exp_grant.size() + exp_done.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        tv = '0;
        for (int k = 0; k < NR; k++) begin
            t_addr[k] = '0; t_wdata[k] = '0; t_wstrb[k] = '0;
        end
        resp_en = 1; resp_force = 0; resp_use_addr = 0; resp_slverr = 0;
        resp_delay = 1; resp_rdata = '0;

        // Reset: outputs stay 0 even with every requester asking.
        tv = '1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid_busy", 64'({m_valid, busy}), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_payload", 64'({m_addr, m_wdata, m_wstrb}), 64'd0);
        chk("rst_resp", 64'({req_rdata, req_slverr, req_timeout}), 64'd0);
        tv = '0;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read from requester 1.
        t_addr[1] = 24'h00_1234; t_wdata[1] = 32'h1111_2222; t_wstrb[1] = 4'h0;
        resp_delay = 4; resp_rdata = 32'hDEAD_BEEF; resp_slverr = 0;
        exp_grant.push_back(1);
        exp_done.push_back(mk_done(1, 32'hDEAD_BEEF, 0, 0, 4));
        issue(1);
        chk("read_addr", 64'(m_addr), 64'h00_1234);
        wait_drained(60);

        // Write with slave error from requester 2.
        t_addr[2] = 24'h00_8000; t_wdata[2] = 32'hA5A5_A5A5; t_wstrb[2] = 4'hF;
        resp_delay = 3; resp_rdata = 32'h1234_5678; resp_slverr = 1;
        exp_grant.push_back(2);
        exp_done.push_back(mk_done(2, 32'h1234_5678, 1, 0, 3));
        issue(2);
        chk("write_wstrb", 64'(m_wstrb), 64'hF);
        chk("write_wdata", 64'(m_wdata), 64'hA5A5_A5A5);
        wait_drained(60);

        // Payload change and valid drop while BUSY.
        t_addr[0] = 24'h00_ABCD; t_wdata[0] = 32'h0000_0042; t_wstrb[0] = 4'h3;
        resp_delay = 5; resp_use_addr = 1; resp_slverr = 0;
        exp_grant.push_back(0);
        exp_done.push_back(mk_done(0, {8'h5A, 24'h00_ABCD}, 0, 0, 5));
        issue(0);
        @(posedge clk); #2 t_addr[0] = 24'hFF_FFFF;
        @(negedge clk);
        chk("payload_latched", 64'(m_addr), 64'h00_ABCD);
        wait_drained(60);
        t_addr[0] = 24'h00_ABCD;
        resp_use_addr = 0;

        // Timeout with no downstream answer.
        t_addr[3] = 24'h03_0303; t_wdata[3] = 32'h3333_3333; t_wstrb[3] = 4'h1;
        resp_en = 0;
        exp_grant.push_back(3);
        exp_done.push_back(mk_done(3, '0, 0, 1, TO));
        issue(3);
        wait_drained(60);

        // Ready on the same edge as the timeout: ready wins.
        resp_en = 1; resp_delay = TO; resp_rdata = 32'hC0C0_C0C0;
        exp_grant.push_back(1);
        exp_done.push_back(mk_done(1, 32'hC0C0_C0C0, 0, 0, TO));
        issue(1);
        wait_drained(60);

        // Downstream ready held in IDLE and RELEASE must be ignored.
        resp_force = 1; resp_rdata = 32'h0F0F_0F0F; resp_slverr = 0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ready_ignored", 64'({busy, req_ready}), 64'd0);
        end
        exp_grant.push_back(0);
        exp_done.push_back(mk_done(0, 32'h0F0F_0F0F, 0, 0, 1));
        issue(0);
        wait_drained(60);
        resp_force = 0;

        // Contention from reset: all four held valid, minimum-length BUSY.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < NR; k++) begin
            t_addr[k]  = 24'(32'h10_0000 + k * 32'h1111);
            t_wdata[k] = 32'hCAFE_0000 + 32'(k);
            t_wstrb[k] = 4'(k + 1);
        end
        resp_delay = 1; resp_use_addr = 1;
        foreach (exp_grant[i]) exp_grant.delete(i);
        for (int i = 0; i < 5; i++) begin
            exp_grant.push_back(i % NR);
            exp_done.push_back(mk_done(i % NR, {8'h5A, t_addr[i % NR]}, 0, 0, 1));
        end
        tv = '1;
        for (int i = 0; i < 5; i++) wait_grant(40);
        tv = '0;
        wait_drained(60);
        resp_use_addr = 0;

        // Reset mid-BUSY: move the pointer to 1 so plain round-robin would
        // pick 3, then check reset priority picks 1 instead.
        resp_rdata = 32'h600D_F00D;
        exp_grant.push_back(1);
        exp_done.push_back(mk_done(1, 32'h600D_F00D, 0, 0, 1));
        issue(1);
        wait_drained(60);
        resp_en = 0;
        exp_grant.push_back(3);
        tv = 4'b1010;
        wait_grant(40);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy_valid", 64'({m_valid, busy}), 64'd0);
        chk("rst_busy_ready", 64'(req_ready), 64'd0);
        chk("rst_busy_grant", 64'(grant_id), 64'd0);
        chk("rst_busy_addr", 64'(m_addr), 64'd0);
        repeat (2) @(negedge clk);
        resp_en = 1; resp_delay = 2;
        exp_grant.push_back(1);
        exp_done.push_back(mk_done(1, 32'h600D_F00D, 0, 0, 2));
        exp_grant.push_back(3);
        exp_done.push_back(mk_done(3, 32'h600D_F00D, 0, 0, 2));
        rst_n = 1'b1;
        wait_grant(40);
        chk("post_rst_grant", 64'(grant_id), 64'd1);
        tv[1] = 1'b0;
        wait_grant(40);
        tv[3] = 1'b0;
        wait_drained(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
